// File: rtl/btn_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the button event path. Every consumer of button
// events imports this package so that all of them agree on state encoding
// and on the default long-press / auto-repeat timing.
//
// Contents:
//   btn_state_e        - 2-bit FSM state encoding (IDLE / PRESSED / HELD)
//   LONG_CYCLES_DEF    - default hold time before a Long event
//   REPEAT_CYCLES_DEF  - default auto-repeat period after Long
//   CNT_W_DEF          - default hold-counter width
// ---------------------------------------------------------------------------
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } btn_state_e;

  localparam int LONG_CYCLES_DEF   = 25_000_000;
  localparam int REPEAT_CYCLES_DEF = 5_000_000;
  localparam int CNT_W_DEF         = 25;

endpackage

// File: rtl/btn_cycle_timer.sv
// ---------------------------------------------------------------------------
// btn_cycle_timer
// CNT_W-bit up-counter with synchronous clear and count enable. It raises
// term_hit for the single cycle in which the count equals term_val while
// enabled; on that edge the count wraps back to zero so the next period
// starts immediately.
//
// Ports:
//   Clock     in   system clock
//   Reset_n   in   asynchronous active-low reset
//   clear     in   force count to zero (dominates enable)
//   enable    in   advance the count this cycle
//   term_val  in   terminal count value (period - 1)
//   term_hit  out  combinational terminal flag, high one cycle per period
// ---------------------------------------------------------------------------
module btn_cycle_timer #(
  parameter int CNT_W = 25
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] term_val,
  output logic             term_hit
);

  logic [CNT_W-1:0] count_q;

  assign term_hit = enable && !clear && (count_q == term_val);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= term_hit ? '0 : count_q + 1'b1;
    end
  end

endmodule

// File: rtl/btn_event_gen.sv
// ---------------------------------------------------------------------------
// btn_event_gen
// Turns the debounced, Clock-synchronous button level into single-cycle
// event pulses (Press, Release, Long, Repeat), a Held level and a wrapping
// 8-bit press counter. All outputs are registered.
//
// Optional feature macro: BTN_REPEAT_EN
//   defined   - auto-repeat pulses every REPEAT_CYCLES while in HELD
//   undefined - Repeat tied low, hold counter parked at zero in HELD,
//               REPEAT_CYCLES has no effect
//
// Ports:
//   Clock        in   system clock, posedge
//   Reset_n      in   asynchronous active-low reset
//   BTN_In       in   debounced button level, 1 = pressed
//   Press        out  one-cycle pulse on press
//   Release      out  one-cycle pulse on release
//   Long         out  one-cycle pulse when the hold reaches LONG_CYCLES
//   Repeat       out  one-cycle pulse every REPEAT_CYCLES after Long
//   Held         out  level, high while the FSM is not IDLE
//   Press_Count  out  number of presses, modulo 256
//
// The current FSM state is visible for debug/checkers as state_q.
// ---------------------------------------------------------------------------
module btn_event_gen
  import btn_pkg::*;
#(
  parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       BTN_In,
  output logic       Press,
  output logic       Release,
  output logic       Long,
  output logic       Repeat,
  output logic       Held,
  output logic [7:0] Press_Count
);

  // Elaboration-time parameter sanity checks.
  localparam int MAX_CYCLES = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;

  if (LONG_CYCLES < 2) begin : g_bad_long
    $error("btn_event_gen: LONG_CYCLES must be >= 2");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("btn_event_gen: REPEAT_CYCLES must be >= 1");
  end
  if ((longint'(1) << CNT_W) <= longint'(MAX_CYCLES)) begin : g_bad_width
    $error("btn_event_gen: CNT_W too small for the configured cycle counts");
  end

  localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CYCLES - 1);

  btn_state_e       state_q;
  btn_state_e       state_d;
  logic             timer_clear;
  logic             timer_en;
  logic [CNT_W-1:0] timer_term;
  logic             timer_hit;

  logic press_d;
  logic release_d;
  logic long_d;
  logic held_d;

  // The counter is zero whenever a press starts and whenever the button is
  // released, so clearing in IDLE and on any low sample covers both.
  assign timer_clear = (state_q == ST_IDLE) || !BTN_In;

`ifdef BTN_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CYCLES - 1);

  logic repeat_d;

  assign timer_en   = BTN_In && (state_q != ST_IDLE);
  assign timer_term = (state_q == ST_HELD) ? REPEAT_TERM : LONG_TERM;
`else
  // Without auto-repeat the counter only runs in PRESSED; it wraps to zero
  // on the Long edge and then stays there for the rest of the hold.
  assign timer_en   = BTN_In && (state_q == ST_PRESSED);
  assign timer_term = LONG_TERM;
`endif

  btn_cycle_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .clear    (timer_clear),
    .enable   (timer_en),
    .term_val (timer_term),
    .term_hit (timer_hit)
  );

  // State register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A low sample always wins, so a release at the edge
  // where Long would fire returns straight to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (BTN_In) state_d = ST_PRESSED;
      end
      ST_PRESSED: begin
        if (!BTN_In)        state_d = ST_IDLE;
        else if (timer_hit) state_d = ST_HELD;
      end
      ST_HELD: begin
        if (!BTN_In) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode (registered below). Press only from IDLE and Release only
  // from a non-IDLE state, so the two can never coincide.
  always_comb begin
    press_d   = (state_q == ST_IDLE) && BTN_In;
    release_d = (state_q != ST_IDLE) && !BTN_In;
    long_d    = (state_q == ST_PRESSED) && BTN_In && timer_hit;
    held_d    = (state_d != ST_IDLE);
  end

`ifdef BTN_REPEAT_EN
  always_comb begin
    repeat_d = (state_q == ST_HELD) && BTN_In && timer_hit;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Repeat <= 1'b0;
    end else begin
      Repeat <= repeat_d;
    end
  end
`else
  assign Repeat = 1'b0;
`endif

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Press       <= 1'b0;
      Release     <= 1'b0;
      Long        <= 1'b0;
      Held        <= 1'b0;
      Press_Count <= 8'd0;
    end else begin
      Press   <= press_d;
      Release <= release_d;
      Long    <= long_d;
      Held    <= held_d;
      if (press_d) Press_Count <= Press_Count + 8'd1;
    end
  end

endmodule

// File: doc/btn_event_gen.md
Name: btn_event_gen

Overview:
- Consumes the debounced, Clock-synchronous button level from the button anti-jitter stage.
- Converts that level into single-cycle event pulses: press, release, long-press and auto-repeat.
- Also provides a wrapping press counter.
- Sits between the debouncer and the CPU test-harness control logic (single-step, display-mode select), so that a held button never issues more than the intended commands.

Parameters:
- LONG_CYCLES, 25_000_000, cycles the button must stay held after the press pulse before Long fires; legal range ≥ 2.
- REPEAT_CYCLES, 5_000_000, period of Repeat pulses after Long; legal range ≥ 1.
- CNT_W, 25, hold-counter width; must satisfy 2^CNT_W > max(LONG_CYCLES, REPEAT_CYCLES).

Ports:
- Clock  in  1  system clock; all logic on posedge.
- Reset_n  in  1  asynchronous active-low reset.
- BTN_In  in  1  debounced button level, already synchronous to Clock; 1 = pressed.
- Press  out  1  one-cycle pulse on press.
- Release  out  1  one-cycle pulse on release.
- Long  out  1  one-cycle pulse when the hold reaches LONG_CYCLES.
- Repeat  out  1  one-cycle pulse every REPEAT_CYCLES after Long.
- Held  out  1  level; 1 while state ≠ IDLE.
- Press_Count  out  8  number of presses, wraps modulo 256.

Behaviour:
- Reset (Reset_n = 0, asynchronous): state = IDLE, counter = 0, Press/Release/Long/Repeat/Held = 0, Press_Count = 0.
- All outputs are registered. Event pulses are high for exactly one Clock cycle.
- States: IDLE, PRESSED, HELD.
- IDLE:
  - On an edge sampling BTN_In = 1: go to PRESSED, counter ← 0, Press = 1, Press_Count ← Press_Count + 1 (255 → 0).
  - Latency: BTN_In high before edge k gives Press high from edge k to edge k+1.
- PRESSED:
  - BTN_In = 0 at an edge: go to IDLE, Release = 1, counter ← 0.
  - Else if counter == LONG_CYCLES−1: go to HELD, Long = 1, counter ← 0.
  - Else: counter ← counter + 1.
  - Net timing: Long is high in the cycle starting exactly LONG_CYCLES edges after the Press edge, provided BTN_In is sampled 1 on every intervening edge.
- HELD:
  - BTN_In = 0: go to IDLE, Release = 1, counter ← 0.
  - Else if counter == REPEAT_CYCLES−1: Repeat = 1, counter ← 0.
  - Else: counter ← counter + 1.
  - First Repeat follows Long by REPEAT_CYCLES edges, then recurs every REPEAT_CYCLES edges.
- Held is 1 in PRESSED and HELD; it falls on the same edge as the Release pulse.
- Simultaneous events:
  - A release at the edge where Long or Repeat would fire yields Release only.
  - Press and Release are never high together.
- Re-press: a 0 sample followed by a 1 sample gives Release in one cycle and Press in the next; there is no dead time.
- Button held across reset deassertion: the first edge after reset samples 1 and emits Press.
- Reset mid-hold: all state is discarded immediately and no Release is emitted.

Optional Feature:
- Macro: BTN_REPEAT_EN.
- Defined: HELD behaves as above and Repeat pulses are generated.
- Undefined:
  - Repeat is tied to 0.
  - In HELD the counter holds at 0 and no Repeat logic is synthesized.
  - HELD exits only on release.
  - REPEAT_CYCLES is ignored.

Decomposition:
- Shared package btn_pkg holds:
  - 2-bit state encoding constants: ST_IDLE = 2'd0, ST_PRESSED = 2'd1, ST_HELD = 2'd2.
  - The default LONG_CYCLES and REPEAT_CYCLES values, so all button consumers agree on timing.
- One natural sub-module: btn_cycle_timer (CNT_W-bit counter).
  - Inputs: clear, enable, terminal-count value.
  - Output: single-cycle terminal flag.
  - Instantiated once; the terminal value is muxed by state.

Test Plan (LONG_CYCLES = 8, REPEAT_CYCLES = 4):
1. Reset behaviour: assert Reset_n = 0 mid-cycle with BTN_In = 1 → all outputs 0 immediately; release Reset_n → Press at the first edge, Press_Count = 1.
2. Short tap: BTN_In high for 3 edges, then low → Press at edge 0, Release at edge 3; Long and Repeat never assert; Held high for 3 cycles.
3. Long hold, BTN_REPEAT_EN defined: hold 20 edges → Press at edge 0, Long at edge 8, Repeat at edges 12 and 16, Release at edge 20.
4. Release coinciding with Long: BTN_In drops so that edge 8 samples 0 → Release at edge 8, no Long pulse.
5. Counter wrap: 256 taps → Press_Count returns to 0. Back-to-back tap with a single low sample → Release then Press on consecutive edges.
6. BTN_REPEAT_EN undefined: hold 30 edges → Long at edge 8, Repeat stays 0, Release at edge 30.
